crc_serial_chk: RTL and testbench

//  Parametrised serial CRC generator/checker for the USB receive path; supersedes the fixed 16-bit checker.

---
 rtl/crc_pkg.sv | 25 ++
 rtl/crc_lfsr_step.sv | 18 +
 rtl/crc_serial_chk.sv | 141 ++++++++++++++
 tb/tb_crc_serial_chk.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and USB CRC constants for the serial CRC generator/checker family.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } crc_state_t;

   localparam logic [4:0]  USB_CRC5_POLY     = 5'h05;
   localparam logic [4:0]  USB_CRC5_INIT     = 5'h1F;
   localparam logic [4:0]  USB_CRC5_RESIDUE  = 5'h0C;

   localparam logic [15:0] USB_CRC16_POLY    = 16'h8005;
   localparam logic [15:0] USB_CRC16_INIT    = 16'hFFFF;
   localparam logic [15:0] USB_CRC16_RESIDUE = 16'h800D;

   // Width of the optional frame-length counter; large enough for the longest USB packet.
   localparam int LEN_CNT_W = 14;

   function automatic logic [LEN_CNT_W-1:0] len_sat_inc(input logic [LEN_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational single-bit CRC step (MSB-first LFSR); shared by the receive checker and the tx generator.
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = USB_CRC16_POLY
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic             d_i,
   output logic [CRC_W-1:0] crc_n_o
);

   logic fb;

   assign fb      = crc_i[CRC_W-1] ^ d_i;
   assign crc_n_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_serial_chk.sv
// Parametrised serial CRC checker: frames one decoded bit per enabled cycle between init and eop.
// Optional frame-length check enabled by defining CRC_LEN_CHECK_EN (adds the len_err output).
module crc_serial_chk
   import crc_pkg::*;
#(
   parameter int               CRC_W    = 16,
   parameter logic [CRC_W-1:0] POLY     = USB_CRC16_POLY,
   parameter logic [CRC_W-1:0] INIT     = USB_CRC16_INIT,
   parameter logic [CRC_W-1:0] RESIDUE  = USB_CRC16_RESIDUE,
   parameter int               MAX_BITS = 8192
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             enable,
   input  logic             d_decoded,
   input  logic             eop,
   output logic [CRC_W-1:0] crc_out,
   output logic             busy,
   output logic             done,
   output logic             crc_ok
`ifdef CRC_LEN_CHECK_EN
   ,
   output logic             len_err
`endif
);

   if (CRC_W < 5 || CRC_W > 32) begin : g_bad_crc_w
      $error("crc_serial_chk: CRC_W must be within 5..32");
   end
   if (MAX_BITS < CRC_W || MAX_BITS > (2 ** LEN_CNT_W) - 1) begin : g_bad_max_bits
      $error("crc_serial_chk: MAX_BITS must fit the length counter and cover the CRC");
   end

   crc_state_t       state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic [CRC_W-1:0] crc_step;
   logic [CRC_W-1:0] crc_acc;
   logic             done_q, done_d;
   logic             ok_q, ok_d;
   logic             len_bad;

   crc_lfsr_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_step (
      .crc_i   (crc_q),
      .d_i     (d_decoded),
      .crc_n_o (crc_step)
   );

   // Post-step value: an eop arriving with the last bit is judged after that bit is folded in.
   assign crc_acc = enable ? crc_step : crc_q;

`ifdef CRC_LEN_CHECK_EN
   localparam logic [LEN_CNT_W-1:0] MIN_LEN = LEN_CNT_W'(CRC_W);
   localparam logic [LEN_CNT_W-1:0] MAX_LEN = LEN_CNT_W'(MAX_BITS);

   logic [LEN_CNT_W-1:0] cnt_q, cnt_d;
   logic [LEN_CNT_W-1:0] cnt_acc;
   logic                 len_err_q, len_err_d;

   assign cnt_acc = enable ? len_sat_inc(cnt_q) : cnt_q;
   assign len_bad = (cnt_acc < MIN_LEN) || (cnt_acc > MAX_LEN);

   always_comb begin
      cnt_d     = cnt_q;
      len_err_d = len_err_q;
      if (init) begin
         cnt_d     = '0;
         len_err_d = 1'b0;
      end else if (state_q == ACCUM) begin
         cnt_d = cnt_acc;
         if (eop) begin
            len_err_d = len_bad;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign len_err = len_err_q;
`else
   assign len_bad = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
      state_d = state_q;
      crc_d   = crc_q;
      done_d  = 1'b0;
      ok_d    = ok_q;
      if (init) begin
         state_d = ACCUM;
         crc_d   = INIT;
         ok_d    = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               crc_d = crc_acc;
               if (eop) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  ok_d    = (crc_acc == RESIDUE) && !len_bad;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
      end
   end

   assign crc_out = crc_q;
   assign busy    = (state_q == ACCUM);
   assign done    = done_q;
   assign crc_ok  = ok_q;

endmodule

// File: tb/tb_crc_serial_chk.sv
// Self-checking bench: CRC5, CRC16 and INIT=0 CRC16 checkers share one stimulus stream,
// compared every cycle against a polynomial-division reference model.
module tb_crc_serial_chk;

   localparam int NK = 3;
   localparam int          P_W    [NK] = '{5, 16, 16};
   localparam logic [31:0] P_POLY [NK] = '{32'h05, 32'h8005, 32'h8005};
   localparam logic [31:0] P_INIT [NK] = '{32'h1F, 32'hFFFF, 32'h0000};
   localparam logic [31:0] P_RES  [NK] = '{32'h0C, 32'h800D, 32'h0000};
   localparam int MAX_BITS = 8192;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0, init = 1'b0, enable = 1'b0, d_decoded = 1'b0, eop = 1'b0;
   logic [4:0]    crc5;
   logic [15:0]   crc16, crc0;
   logic [NK-1:0] busy, done, ok, len_err;

   crc_serial_chk #(.CRC_W(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C), .MAX_BITS(MAX_BITS)) u_crc5 (
      .clk(clk), .rst(rst), .init(init), .enable(enable), .d_decoded(d_decoded), .eop(eop),
      .crc_out(crc5), .busy(busy[0]), .done(done[0]), .crc_ok(ok[0])
`ifdef CRC_LEN_CHECK_EN
      , .len_err(len_err[0])
`endif
   );

   crc_serial_chk #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D), .MAX_BITS(MAX_BITS)) u_crc16 (
      .clk(clk), .rst(rst), .init(init), .enable(enable), .d_decoded(d_decoded), .eop(eop),
      .crc_out(crc16), .busy(busy[1]), .done(done[1]), .crc_ok(ok[1])
`ifdef CRC_LEN_CHECK_EN
      , .len_err(len_err[1])
`endif
   );

   crc_serial_chk #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .RESIDUE(16'h0000), .MAX_BITS(MAX_BITS)) u_crc0 (
      .clk(clk), .rst(rst), .init(init), .enable(enable), .d_decoded(d_decoded), .eop(eop),
      .crc_out(crc0), .busy(busy[2]), .done(done[2]), .crc_ok(ok[2])
`ifdef CRC_LEN_CHECK_EN
      , .len_err(len_err[2])
`endif
   );

`ifndef CRC_LEN_CHECK_EN
   assign len_err = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   bit msg_q[$];
   bit calc_q[$];
   bit frame_q[$];
   bit m_active = 1'b0;
   bit m_valid  = 1'b0;
   bit m_done   = 1'b0;
   bit m_ok  [NK];
   bit m_len [NK];

   // Register after the bits in calc_q = (INIT*x^n + M(x)*x^W) mod G(x), by long division.
   function automatic logic [31:0] model_crc(input int k);
      int          n = calc_q.size();
      int          w = P_W[k];
      logic [32:0] g = {1'b0, P_POLY[k]} | (33'd1 << w);
      bit          a[$];
      logic [31:0] r = '0;
      for (int p = 0; p < n + w; p++) a.push_back(1'b0);
      for (int j = 0; j < w; j++) a[n + j] = a[n + j] ^ P_INIT[k][j];
      for (int i = 0; i < n; i++) a[n - 1 - i + w] = a[n - 1 - i + w] ^ calc_q[i];
      for (int p = n + w - 1; p >= w; p--) begin
         if (a[p]) begin
            for (int j = 0; j <= w; j++) a[p - w + j] = a[p - w + j] ^ g[j];
         end
      end
      for (int j = 0; j < w; j++) r[j] = a[j];
      return r;
   endfunction

   function automatic logic [31:0] dut_crc(input int k);
      case (k)
         0:       return {27'd0, crc5};
         1:       return {16'd0, crc16};
         default: return {16'd0, crc0};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic update_model();
      logic [31:0] c;
      bit          lb;
      if (rst) begin
         m_active = 1'b0; m_valid = 1'b0; m_done = 1'b0;
         msg_q.delete();
         for (int k = 0; k < NK; k++) begin m_ok[k] = 1'b0; m_len[k] = 1'b0; end
      end else if (init) begin
         m_active = 1'b1; m_valid = 1'b1; m_done = 1'b0;
         msg_q.delete();
         for (int k = 0; k < NK; k++) begin m_ok[k] = 1'b0; m_len[k] = 1'b0; end
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            if (enable) msg_q.push_back(d_decoded);
            if (eop) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               calc_q   = msg_q;
               for (int k = 0; k < NK; k++) begin
                  c  = model_crc(k);
                  lb = 1'b0;
`ifdef CRC_LEN_CHECK_EN
                  lb = (msg_q.size() < P_W[k]) || (msg_q.size() > MAX_BITS);
`endif
                  m_len[k] = lb;
                  m_ok[k]  = !lb && (c == P_RES[k]);
               end
            end
         end
      end
   endtask

   task automatic check_all();
      calc_q = msg_q;
      for (int k = 0; k < NK; k++) begin
         check($sformatf("crc_out[%0d]", k), dut_crc(k), m_valid ? model_crc(k) : 32'd0);
         check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_active));
         check($sformatf("done[%0d]", k), 32'(done[k]), 32'(m_done));
         check($sformatf("crc_ok[%0d]", k), 32'(ok[k]), 32'(m_ok[k]));
`ifdef CRC_LEN_CHECK_EN
         check($sformatf("len_err[%0d]", k), 32'(len_err[k]), 32'(m_len[k]));
`endif
      end
   endtask

   task automatic cyc(input bit r, input bit i, input bit e, input bit dd, input bit p);
      rst = r; init = i; enable = e; d_decoded = dd; eop = p;
      @(posedge clk);
      update_model();
      #1;
      check_all();
   endtask

   // Append the register value after frame_q, MSB first; complemented except for the INIT=0 checker.
   task automatic append_crc(input int k);
      logic [31:0] c;
      calc_q = frame_q;
      c = model_crc(k);
      for (int j = P_W[k] - 1; j >= 0; j--) frame_q.push_back((k == 2) ? c[j] : ~c[j]);
   endtask

   task automatic send_frame(input bit eop_with_last, input bit gaps);
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < frame_q.size(); i++) begin
         while (gaps && $urandom_range(3) == 0) cyc(0, 0, 0, 1'($urandom), 0);
         cyc(0, 0, 1, frame_q[i], eop_with_last && (i == frame_q.size() - 1));
      end
      if (!eop_with_last) cyc(0, 0, 0, 0, 1);
   endtask

   initial begin
      int k, nb, fi;
      bit bad, with_last;

      // Reset dominates an active enable/data.
      cyc(1, 0, 1, 1, 0);
      cyc(1, 0, 1, 1, 0);
      check("rst crc_out", {16'd0, crc16}, 32'd0);
      check("rst busy", {29'd0, busy}, 32'd0);
      check("rst done", {29'd0, done}, 32'd0);
      check("rst crc_ok", {29'd0, ok}, 32'd0);

      // INIT=0 checker: bits 1 then 0.
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0);
      check("init0 bit1", {16'd0, crc0}, 32'h8005);
      cyc(0, 0, 1, 0, 0);
      check("init0 bit0", {16'd0, crc0}, 32'h800F);
      check("init0 busy", 32'(busy[2]), 32'd1);
      cyc(0, 0, 0, 0, 1);

      // CRC5 token address with its complemented CRC5.
      frame_q = '{1, 1, 0, 0, 1, 1, 1, 1};
      append_crc(0);
      send_frame(0, 0);
      check("crc5 done", 32'(done[0]), 32'd1);
      check("crc5 ok", 32'(ok[0]), 32'd1);
      check("crc5 residue", {27'd0, crc5}, 32'h0C);

      // CRC16 frame with one payload bit flipped, started back-to-back while done is high.
      frame_q = '{1, 1, 0, 0, 1, 1, 1, 1};
      append_crc(1);
      frame_q[2] = ~frame_q[2];
      send_frame(0, 0);
      check("crc16 bad done", 32'(done[1]), 32'd1);
      check("crc16 bad ok", 32'(ok[1]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 1, 1);
         check("crc16 bad ok held", 32'(ok[1]), 32'd0);
      end

      // eop together with the last CRC bit, then init+eop in the same cycle.
      frame_q.delete();
      for (int i = 0; i < 20; i++) frame_q.push_back(1'($urandom));
      append_crc(1);
      send_frame(1, 0);
      check("crc16 eop+en ok", 32'(ok[1]), 32'd1);
      cyc(0, 1, 1, 1, 1);
      check("init+eop crc_out", {16'd0, crc16}, 32'hFFFF);
      check("init+eop done", {29'd0, done}, 32'd0);
      cyc(0, 0, 0, 0, 0);
      check("init+eop no pulse", {29'd0, done}, 32'd0);

      // Reset in the middle of a frame; a following eop is ignored.
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1'($urandom), 0);
      cyc(1, 0, 1, 1, 0);
      check("midrst crc_out", {16'd0, crc16}, 32'd0);
      check("midrst busy", {29'd0, busy}, 32'd0);
      cyc(0, 0, 0, 0, 1);
      check("midrst eop done", {29'd0, done}, 32'd0);

      // Too-short frame.
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1'($urandom), 0);
      cyc(0, 0, 0, 0, 1);
      check("short ok", {29'd0, ok}, 32'd0);
`ifdef CRC_LEN_CHECK_EN
      check("short len_err", {29'd0, len_err}, 32'h7);
`endif

      // Randomised frames for each checker, good or corrupted, with enable gaps.
      for (int f = 0; f < 12; f++) begin
         k         = int'($urandom_range(NK - 1));
         nb        = int'($urandom_range(24, 6));
         bad       = 1'($urandom);
         with_last = 1'($urandom);
         frame_q.delete();
         for (int i = 0; i < nb; i++) frame_q.push_back(1'($urandom));
         append_crc(k);
         if (bad) begin
            fi = int'($urandom_range(nb - 1));
            frame_q[fi] = ~frame_q[fi];
         end
         send_frame(with_last, 1);
         check($sformatf("rand%0d done[%0d]", f, k), 32'(done[k]), 32'd1);
         check($sformatf("rand%0d ok[%0d]", f, k), 32'(ok[k]), 32'(!bad));
         if (!bad) check($sformatf("rand%0d residue[%0d]", f, k), dut_crc(k), P_RES[k]);
      end
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
